// File: rtl/mux41_pkg.sv
// Shared select-code type and constants for the registered 4:1 mux.
package mux41_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D1 = 2'b00;
  localparam sel_t SEL_D2 = 2'b01;
  localparam sel_t SEL_D3 = 2'b10;
  localparam sel_t SEL_D4 = 2'b11;

endpackage

// File: rtl/mux41_comb.sv
// Purely combinational WIDTH-bit 4:1 select.
module mux41_comb
  import mux41_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  output logic [WIDTH-1:0] out_c
);

  // Default arm keeps an unknown select from propagating X downstream.
  always_comb begin
    out_c = d1;
    case (sel)
      SEL_D1:  out_c = d1;
      SEL_D2:  out_c = d2;
      SEL_D3:  out_c = d3;
      SEL_D4:  out_c = d4;
      default: out_c = d1;
    endcase
  end

endmodule

// File: rtl/mux41_reg.sv
// Registered 4:1 mux with capture enable and one-cycle valid flag.
// Optional even-parity output is enabled by defining MUX41_PARITY_EN.
module mux41_reg
  import mux41_pkg::*;
#(
  parameter int unsigned     WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  sel_t             sel,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
`ifdef MUX41_PARITY_EN
  output logic             y_parity,
`endif
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  logic [WIDTH-1:0] sel_data_c;
  logic [WIDTH-1:0] y_d, y_q;
  logic             valid_d, valid_q;

  mux41_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .sel   (sel),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .d4    (d4),
    .out_c (sel_data_c)
  );

  // Next state: capture on en, otherwise hold data and drop valid.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (en) begin
      y_d     = sel_data_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y       = y_q;
  assign y_valid = valid_q;

`ifdef MUX41_PARITY_EN
  logic parity_d, parity_q;

  // Parity is computed from the mux output so it lands with the same edge as y.
  always_comb begin
    parity_d = parity_q;
    if (en) parity_d = ^sel_data_c;
  end

  always_ff @(posedge clk) begin
    if (rst) parity_q <= ^RESET_VAL;
    else     parity_q <= parity_d;
  end

  assign y_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux41_reg.sv
// Directed self-checking bench for mux41_reg (narrow and 8-bit instances).
module tb_mux41_reg;
  import mux41_pkg::*;

  localparam logic [7:0] W_RST = 8'h58;

  logic       clk;
  logic       rst;
  logic       en;
  sel_t       sel;
  logic       n1, n2, n3, n4;
  logic       yn, vn;
  logic [7:0] w1, w2, w3, w4;
  logic [7:0] yw;
  logic       vw;
`ifdef MUX41_PARITY_EN
  logic       pn, pw;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux41_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_narrow (
    .clk (clk), .rst (rst), .en (en), .sel (sel),
    .d1 (n1), .d2 (n2), .d3 (n3), .d4 (n4),
`ifdef MUX41_PARITY_EN
    .y_parity (pn),
`endif
    .y (yn), .y_valid (vn)
  );

  mux41_reg #(.WIDTH(8), .RESET_VAL(W_RST)) u_wide (
    .clk (clk), .rst (rst), .en (en), .sel (sel),
    .d1 (w1), .d2 (w2), .d3 (w3), .d4 (w4),
`ifdef MUX41_PARITY_EN
    .y_parity (pw),
`endif
    .y (yw), .y_valid (vw)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks every output of both instances against one expected state.
  task automatic check_all(input string tag, input logic en_n, input logic [7:0] en_w,
                           input logic exp_v);
    check({tag, " y1"}, 8'(yn), 8'(en_n));
    check({tag, " v1"}, 8'(vn), 8'(exp_v));
    check({tag, " y8"}, yw, en_w);
    check({tag, " v8"}, 8'(vw), 8'(exp_v));
`ifdef MUX41_PARITY_EN
    check({tag, " p1"}, 8'(pn), 8'(en_n));
    check({tag, " p8"}, 8'(pw), 8'(^en_w));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic       exp_n [4];
  logic [7:0] exp_w [4];
  logic [7:0] churn;

  initial begin
    exp_n[0] = 1'b0; exp_n[1] = 1'b1; exp_n[2] = 1'b0; exp_n[3] = 1'b1;
    exp_w[0] = 8'hA5; exp_w[1] = 8'h3C; exp_w[2] = 8'hFF; exp_w[3] = 8'h00;

    // Reset with capture requested and busy inputs.
    rst = 1'b1; en = 1'b1; sel = SEL_D4;
    n1 = 1'b1; n2 = 1'b1; n3 = 1'b1; n4 = 1'b1;
    w1 = 8'h11; w2 = 8'h22; w3 = 8'h33; w4 = 8'hEE;
    tick();
    check_all("reset0", 1'b0, W_RST, 1'b0);
    tick();
    check_all("reset1", 1'b0, W_RST, 1'b0);

    // Sweep all four select codes back-to-back.
    rst = 1'b0;
    n1 = exp_n[0]; n2 = exp_n[1]; n3 = exp_n[2]; n4 = exp_n[3];
    w1 = exp_w[0]; w2 = exp_w[1]; w3 = exp_w[2]; w4 = exp_w[3];
    for (int s = 0; s < 4; s++) begin
      sel = sel_t'(s);
      tick();
      check_all($sformatf("sweep%0d", s), exp_n[s], exp_w[s], 1'b1);
    end

    // Hold: inputs and select move while en is low.
    sel = SEL_D2;
    tick();
    check_all("hold_cap", 1'b1, 8'h3C, 1'b1);
    en = 1'b0; sel = SEL_D3;
    tick();
    check_all("hold0", 1'b1, 8'h3C, 1'b0);
    w2 = 8'h07; n2 = 1'b0; sel = SEL_D2;
    tick();
    check_all("hold1", 1'b1, 8'h3C, 1'b0);
    en = 1'b1; sel = SEL_D3;
    tick();
    check_all("resume", 1'b0, 8'hFF, 1'b1);
    sel = SEL_D2;
    tick();
    check_all("odd_par", 1'b0, 8'h07, 1'b1);

    // Reset wins over a same-cycle capture.
    rst = 1'b1; sel = SEL_D4; n4 = 1'b1; w4 = 8'hC3;
    tick();
    check_all("rst_prio", 1'b0, W_RST, 1'b0);
    rst = 1'b0;

    // Churn all data every cycle while capturing d3.
    sel = SEL_D3;
    for (int i = 0; i < 8; i++) begin
      churn = 8'(i * 37 + 1);
      n1 = ~churn[0]; n2 = churn[1]; n3 = churn[0]; n4 = churn[2];
      w1 = ~churn; w2 = churn ^ 8'h55; w3 = churn; w4 = churn + 8'd3;
      tick();
      check_all($sformatf("churn%0d", i), churn[0], churn, 1'b1);
    end

    en = 1'b0;
    tick();
    check_all("final_hold", churn[0], churn, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux41_reg.md
Name: mux41_reg

Overview:
- Registered 4-to-1 multiplexer.
- Selects one of four equal-width data inputs (d1..d4) using a 2-bit select.
- Presents the chosen value on a registered output one clock later, with a valid flag.
- Used as a generic datapath selector wherever a glitch-free, clock-aligned 4-way choice is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of y.
- RESET_VAL, 0 (WIDTH bits), value loaded into y on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  capture enable; when high, the selected input is registered this cycle.
- sel  input  2  select code: 00 selects d1, 01 selects d2, 10 selects d3, 11 selects d4.
- d1  input  WIDTH  data input 1.
- d2  input  WIDTH  data input 2.
- d3  input  WIDTH  data input 3.
- d4  input  WIDTH  data input 4.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  high for exactly the cycle after a capture.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset: on a clk edge with rst=1, y <= RESET_VAL and y_valid <= 0. rst dominates en.
- Reset mid-operation discards any capture in that cycle.
- Capture: on a clk edge with rst=0 and en=1:
  - y <= d[sel], using the mapping in Ports.
  - y_valid <= 1.
  - Latency is exactly 1 cycle from sel/d sampled to y.
- Hold: on a clk edge with rst=0 and en=0, y keeps its value and y_valid <= 0.
- Select mapping is total over all 4 codes. No illegal code exists and no X propagation is permitted from sel.
- Back-to-back captures are allowed every cycle; y_valid stays high continuously. Throughput is 1 sample per cycle.
- sel or d changes while en=0 have no effect on y.
- Data is passed bit-exact. No arithmetic, no width conversion.
- No combinational path from any input to y or y_valid.

Optional Feature:
- Macro: MUX41_PARITY_EN.
- Defined:
  - Adds output y_parity (1 bit), registered alongside y.
  - Equals the XOR-reduction of the captured data (even parity: y_parity makes the total count of ones even).
  - Reset value is the XOR-reduction of RESET_VAL.
  - Holds when en=0.
- Undefined: port y_parity and its register are absent. All other behaviour is identical.

Decomposition:
- Package mux41_pkg:
  - Typedef sel_t (2-bit logic).
  - Constants SEL_D1=2'b00, SEL_D2=2'b01, SEL_D3=2'b10, SEL_D4=2'b11.
- Sub-module mux41_comb: purely combinational WIDTH-parameterised 4:1 select (sel, d1..d4 -> out), instantiated once.
- mux41_reg adds the enable/reset register stage and the optional parity.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and arbitrary inputs -> y=RESET_VAL (0), y_valid=0. With parity enabled, y_parity=0.
- Sweep: WIDTH=1, d1=0, d2=1, d3=0, d4=1, en=1; sel=00,01,10,11 on consecutive cycles, held 20 ns each -> y=0,1,0,1, each 1 cycle after its sel, y_valid=1 throughout.
- Hold: capture sel=01 (y=1), then en=0 and sel=10 -> y stays 1 and y_valid=0 until en returns high.
- Reset priority: rst=1 and en=1 in the same cycle with sel=11, d4=1 -> y=0, y_valid=0.
- Wide data: WIDTH=8, d1=8'hA5, d2=8'h3C, d3=8'hFF, d4=8'h00; sel 00..11 -> y=A5, 3C, FF, 00. With MUX41_PARITY_EN, y_parity=0, 0, 0, 0.
- Input churn: toggle d1..d4 every cycle with en=1, sel=10 -> y tracks d3 delayed by exactly 1 cycle, with no glitches on the sampled values.
